// File: rtl/alu_result_buffer_if.sv
// Issue-side and writeback-side handshake bundle for alu_result_buffer.
// The slave modport is the buffer; the master modport is the ALU/writeback environment.
interface alu_result_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FUNC_WIDTH = 4,
    parameter int REG_WIDTH  = 4
);
    logic                  _valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] _result;
    logic                  _overflow;
    logic                  _compareBit;
    logic [FUNC_WIDTH-1:0] _funcCode;
    logic [REG_WIDTH-1:0]  _destReg;
    logic                  _writeEnable;
    logic                  _wbReady;
    logic                  wbValid;
    logic [DATA_WIDTH-1:0] wbResult;
    logic [REG_WIDTH-1:0]  wbDest;
    logic                  wbWriteEnable;

    modport master (
        output _valid, _result, _overflow, _compareBit, _funcCode, _destReg, _writeEnable,
        output _wbReady,
        input  ready, wbValid, wbResult, wbDest, wbWriteEnable
    );

    modport slave (
        input  _valid, _result, _overflow, _compareBit, _funcCode, _destReg, _writeEnable,
        input  _wbReady,
        output ready, wbValid, wbResult, wbDest, wbWriteEnable
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Execute-stage result buffer: 2-entry in-order skid FIFO toward writeback, plus
// issue-ordered status flags (last compare bit, sticky overflow, saturating overflow count).
module alu_result_buffer #(
    parameter int DATA_WIDTH      = 16,
    parameter int FUNC_WIDTH      = 4,
    parameter int REG_WIDTH       = 4,
    parameter int OVF_COUNT_WIDTH = 8
) (
    input  logic                       _clock,
    input  logic                       _reset,
    alu_result_buffer_if.slave         bus,
    input  logic                       _flush,
    input  logic                       _clearFlags,
    output logic                       compareFlag,
    output logic                       overflowFlag,
    output logic [OVF_COUNT_WIDTH-1:0] overflowCount
);
    // Compare-class function codes occupy the contiguous range FUNC_NOT..FUNC_GRT.
    localparam logic [FUNC_WIDTH-1:0] FUNC_NOT = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = FUNC_WIDTH'(11);
    localparam logic [OVF_COUNT_WIDTH-1:0] OVF_MAX = '1;

    logic [DATA_WIDTH-1:0] resultMem [2];
    logic [REG_WIDTH-1:0]  destMem   [2];
    logic                  weMem     [2];

    logic [1:0] count, countNext;
    logic       rdPtr, rdPtrNext;
    logic       wrPtr, wrPtrNext;
    logic       compareNext, overflowNext;
    logic [OVF_COUNT_WIDTH-1:0] ovfCountNext;

    logic headValid, push, pop, isCompare, ovfPush;

    assign bus.ready = !_reset && (count < 2'd2);
    assign headValid = (count != 2'd0);
    assign push      = bus._valid && bus.ready && !_flush;
    assign pop       = headValid && bus._wbReady && !_flush;
    assign isCompare = (bus._funcCode >= FUNC_NOT) && (bus._funcCode <= FUNC_GRT);
    assign ovfPush   = push && bus._overflow;

    assign bus.wbValid       = headValid;
    assign bus.wbResult      = headValid ? resultMem[rdPtr] : '0;
    assign bus.wbDest        = headValid ? destMem[rdPtr]   : '0;
    assign bus.wbWriteEnable = headValid ? weMem[rdPtr]     : 1'b0;

    always_comb begin
        countNext    = count;
        rdPtrNext    = rdPtr;
        wrPtrNext    = wrPtr;
        compareNext  = compareFlag;
        overflowNext = overflowFlag;
        ovfCountNext = overflowCount;

        if (_flush) begin
            countNext = 2'd0;
            rdPtrNext = 1'b0;
            wrPtrNext = 1'b0;
        end else begin
            if (push) wrPtrNext = ~wrPtr;
            if (pop)  rdPtrNext = ~rdPtr;
            unique case ({push, pop})
                2'b10:   countNext = count + 2'd1;
                2'b01:   countNext = count - 2'd1;
                default: countNext = count;
            endcase
        end

        if (push && isCompare) compareNext = bus._compareBit;

        // Set beats clear; a clear with an overflowing push leaves one event counted.
        if (_clearFlags) begin
            overflowNext = 1'b0;
            ovfCountNext = '0;
        end
        if (ovfPush) begin
            overflowNext = 1'b1;
            if (_clearFlags) begin
                ovfCountNext = OVF_COUNT_WIDTH'(1);
            end else if (overflowCount != OVF_MAX) begin
                ovfCountNext = overflowCount + OVF_COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            count         <= 2'd0;
            rdPtr         <= 1'b0;
            wrPtr         <= 1'b0;
            compareFlag   <= 1'b0;
            overflowFlag  <= 1'b0;
            overflowCount <= '0;
        end else begin
            count         <= countNext;
            rdPtr         <= rdPtrNext;
            wrPtr         <= wrPtrNext;
            compareFlag   <= compareNext;
            overflowFlag  <= overflowNext;
            overflowCount <= ovfCountNext;
        end
    end

    // Payload storage needs no reset: head outputs are gated by headValid.
    always_ff @(posedge _clock) begin
        if (push) begin
            resultMem[wrPtr] <= bus._result;
            destMem[wrPtr]   <= bus._destReg;
            weMem[wrPtr]     <= bus._writeEnable;
        end
    end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Execute-stage output buffer directly downstream of the ALU.
- Captures each valid ALU result with its overflow and compare bits and destination register, then presents it to writeback through a 2-entry valid/ready skid FIFO.
- Maintains architectural status flags: last compare bit, sticky overflow, and a saturating overflow event counter.
- Decouples ALU issue from writeback stalls without losing a result.

Parameters:
DATA_WIDTH, 16, ALU result width (matches definitions package)
FUNC_WIDTH, 4, function code width (matches definitions package)
REG_WIDTH, 4, destination register index width
OVF_COUNT_WIDTH, 8, overflow event counter width

Ports:
_clock  input  1  system clock, all state on rising edge
_reset  input  1  synchronous, active-high reset
_valid  input  1  ALU output valid this cycle
ready  output  1  buffer can accept (combinational)
_result  input  DATA_WIDTH  ALU result
_overflow  input  1  ALU overflow bit
_compareBit  input  1  ALU comparison bit
_funcCode  input  FUNC_WIDTH  function code of the op producing _result
_destReg  input  REG_WIDTH  destination register index
_writeEnable  input  1  op writes the register file
_wbReady  input  1  writeback consumes the head entry this cycle
wbValid  output  1  head entry valid
wbResult  output  DATA_WIDTH  head result
wbDest  output  REG_WIDTH  head destination
wbWriteEnable  output  1  head write enable
_flush  input  1  discard all buffered entries
_clearFlags  input  1  clear sticky overflow and counter
compareFlag  output  1  compare bit of the last accepted compare-class op
overflowFlag  output  1  sticky overflow
overflowCount  output  OVF_COUNT_WIDTH  saturating count of accepted overflowing ops

Behaviour:
- Reset (synchronous, _reset high at the edge): FIFO emptied (count=0, pointers=0). wbValid, wbResult, wbDest, wbWriteEnable, compareFlag, overflowFlag and overflowCount are all 0. While _reset is high, ready=0. Reset overrides every other input, including mid-transfer.
- ready = !_reset && count<2. Push = _valid && ready && !_flush. Pop = wbValid && _wbReady && !_flush.
- FIFO: 2 entries of {result, dest, writeEnable}, in-order. Each entry is stored intact; no field is modified.
- Latency: a push at edge N into an empty FIFO gives wbValid=1 with that entry after edge N (1 cycle). No combinational path from _valid to wbValid.
- Head outputs come from the head entry. When wbValid=0, wbResult, wbDest and wbWriteEnable hold 0.
- Count transitions:
  - push only: +1.
  - pop only: −1.
  - push+pop at count 1: count stays 1; the new entry becomes head after the old one leaves.
  - push at count 2: impossible, because ready=0.
  - pop at count 0: impossible, because wbValid=0.
- Pointer wrap: 1-bit read and write pointers wrap modulo 2.
- _flush: at the edge, count→0 and wbValid→0. Any same-cycle push is dropped and that op causes no flag update. Flags and counter are otherwise untouched.
- compareFlag: on push of an op with FUNC_NOT ≤ _funcCode ≤ FUNC_GRT, it loads _compareBit. Otherwise it holds.
- overflowFlag:
  - Set on push with _overflow=1.
  - Cleared by _clearFlags.
  - Set and clear in the same cycle: set wins, result is 1.
- overflowCount:
  - +1 on push with _overflow=1, saturating at 2^OVF_COUNT_WIDTH−1.
  - _clearFlags alone: count→0.
  - _clearFlags with an overflowing push in the same cycle: count→1.
- Flags update at push time, not at pop time, so flag state reflects issue order even under writeback stall.
- _overflow and _compareBit are ignored when no push occurs.

Test Plan:
- Reset, then push {_result=0x1234, _destReg=3, _writeEnable=1} with _wbReady=1 → next cycle wbValid=1, wbResult=0x1234, wbDest=3; following cycle wbValid=0.
- Hold _wbReady=0, push 0x0001 then 0x0002 → ready=0 after the second push; a third _valid (0x0003) is not accepted. Raise _wbReady → outputs 0x0001 then 0x0002 in order, then ready returns to 1.
- At count 1, push 0xAAAA and pop in the same cycle → count stays 1 and the next head is 0xAAAA.
- Push FUNC_EQL with _compareBit=1, then FUNC_ADD with _compareBit=0 → compareFlag=1 and stays 1. Push FUNC_LSS with _compareBit=0 → compareFlag=0.
- Push 3 ops with _overflow=1 → overflowFlag=1, overflowCount=3. Assert _clearFlags together with an overflowing push → overflowFlag=1, overflowCount=1. Push 300 overflowing ops → overflowCount=255.
- With 2 entries buffered, assert _flush with _valid=1 and _overflow=1 → wbValid=0 and count=0; overflowCount unchanged. Assert _reset while wbValid=1 → all outputs 0 and ready=0 during reset.
